// File: rtl/tff_down_timer.sv
// Loadable down-counter/timer on a T flip-flop chain with one-shot and auto-reload modes.
// Optional prescaler enabled by defining TFF_DOWN_PRESCALE_EN (PRESCALE enabled cycles per decrement).
module tff_down_timer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    if (WIDTH < 2 || WIDTH > 16 || PRESCALE < 2) begin : g_param_check
        $error("tff_down_timer: WIDTH must be 2..16 and PRESCALE >= 2");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] t_chain;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;
    logic             tick_run;

`ifdef TFF_DOWN_PRESCALE_EN
    localparam int unsigned PW = $clog2(PRESCALE);

    logic [PW-1:0] pre_q, pre_d;
    logic          pre_wrap;

    assign pre_wrap = (pre_q == PW'(PRESCALE - 1));
    assign tick     = en & pre_wrap;

    // Phase restarts on load and whenever the timer is not (or no longer) running.
    always_comb begin
        pre_d = pre_q;
        if (load || (state_d != ST_RUN)) begin
            pre_d = '0;
        end else if ((state_q == ST_RUN) && en) begin
            pre_d = pre_wrap ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign tick = en;
`endif

    assign tick_run = tick & (state_q == ST_RUN);

    // Bit i toggles when every lower bit is zero (borrow ripple of a down-count).
    for (genvar i = 0; i < WIDTH; i++) begin : g_tff
        if (i == 0) begin : g_lsb
            assign t_chain[i] = tick_run;
        end else begin : g_upper
            assign t_chain[i] = tick_run & (count_q[i-1:0] == '0);
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q ^ t_chain;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = (load_val != '0) ? ST_RUN : ST_IDLE;
        end else if (tick_run && (count_q == WIDTH'(1))) begin
            tc_d = 1'b1;
            if (auto_reload) begin
                count_d = reload_q;
            end else begin
                count_d = '0;
                state_d = ST_DONE;
            end
        end
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_tff_down_timer.sv
// Directed bench for tff_down_timer: vector table for the main modes plus hand sequences for reset and prescale.
module tb_tff_down_timer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [7:0] load_val;
    logic       auto_reload;
    logic [7:0] count;
    logic       tc;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      name;
        logic       load;
        logic [7:0] lv;
        logic       en;
        logic       ar;
        logic [7:0] c;
        logic       tc;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vq[$];

    tff_down_timer #(.WIDTH(8), .PRESCALE(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .load        (load),
        .load_val    (load_val),
        .auto_reload (auto_reload),
        .count       (count),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic add(input string name, input logic ld, input logic [7:0] lv, input logic e,
                       input logic ar, input logic [7:0] c, input logic t, input logic b, input logic d);
        vec_t v;
        v.name = name; v.load = ld; v.lv = lv; v.en = e; v.ar = ar;
        v.c = c; v.tc = t; v.busy = b; v.done = d;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] c, input logic t, input logic b, input logic d);
        n_tests++;
        if ({count, tc, busy, done} !== {c, t, b, d}) begin
            n_fail++;
            $display("FAIL %s: got count=%h tc=%b busy=%b done=%b, want count=%h tc=%b busy=%b done=%b",
                     name, count, tc, busy, done, c, t, b, d);
        end
    endtask

    task automatic drive(input logic ld, input logic [7:0] lv, input logic e, input logic ar);
        load = ld; load_val = lv; en = e; auto_reload = ar;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked at the same offset.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 8'hAA, 1'b1, 1'b1);
        #1;
        chk("reset_async", 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_held", 8'h00, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, 8'hAA, 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);
        end

`ifndef TFF_DOWN_PRESCALE_EN
        // One-shot from 05
        add("os_load", 1, 8'h05, 1, 0, 8'h05, 0, 1, 0);
        add("os_dec",  0, 8'h00, 1, 0, 8'h04, 0, 1, 0);
        add("os_dec",  0, 8'h00, 1, 0, 8'h03, 0, 1, 0);
        add("os_dec",  0, 8'h00, 1, 0, 8'h02, 0, 1, 0);
        add("os_dec",  0, 8'h00, 1, 0, 8'h01, 0, 1, 0);
        add("os_tc",   0, 8'h00, 1, 0, 8'h00, 1, 0, 1);
        for (int i = 0; i < 10; i++) add("os_hold_done", 0, 8'h00, 1, 0, 8'h00, 0, 0, 1);
        // Auto-reload from 03, reload register keeps 03 while load_val wanders
        add("ar_load", 1, 8'h03, 1, 1, 8'h03, 0, 1, 0);
        for (int k = 0; k < 12; k++) begin
            if (k % 3 == 0)      add("ar_cnt2", 0, 8'hFF, 1, 1, 8'h02, 0, 1, 0);
            else if (k % 3 == 1) add("ar_cnt1", 0, 8'hFF, 1, 1, 8'h01, 0, 1, 0);
            else                 add("ar_tc",   0, 8'hFF, 1, 1, 8'h03, 1, 1, 0);
        end
        // Enable gating and multi-bit borrow 10 -> 0F
        add("gate_load", 1, 8'h10, 0, 0, 8'h10, 0, 1, 0);
        add("gate_carry",0, 8'h00, 1, 0, 8'h0F, 0, 1, 0);
        add("gate_hold", 0, 8'h00, 0, 0, 8'h0F, 0, 1, 0);
        add("gate_dec",  0, 8'h00, 1, 0, 8'h0E, 0, 1, 0);
        add("gate_hold", 0, 8'h00, 0, 0, 8'h0E, 0, 1, 0);
        add("gate_dec",  0, 8'h00, 1, 0, 8'h0D, 0, 1, 0);
        // Load of zero goes idle with no pulse; en ignored in idle
        add("zero_load", 1, 8'h00, 1, 0, 8'h00, 0, 0, 0);
        add("idle_en",   0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
        // Load at count==1 wins over the terminal decrement
        add("col_load",  1, 8'h02, 1, 0, 8'h02, 0, 1, 0);
        add("col_dec",   0, 8'h00, 1, 0, 8'h01, 0, 1, 0);
        add("col_hit",   1, 8'hA0, 1, 0, 8'hA0, 0, 1, 0);
        add("col_after", 0, 8'h00, 1, 0, 8'h9F, 0, 1, 0);
        // tick low at count==1 holds without tc
        add("hold_load", 1, 8'h02, 1, 0, 8'h02, 0, 1, 0);
        add("hold_dec",  0, 8'h00, 1, 0, 8'h01, 0, 1, 0);
        add("hold_one",  0, 8'h00, 0, 0, 8'h01, 0, 1, 0);
        add("hold_one",  0, 8'h00, 0, 0, 8'h01, 0, 1, 0);
        add("hold_tc",   0, 8'h00, 1, 0, 8'h00, 1, 0, 1);
        // auto_reload only matters at the count==1 decrement
        add("ars_load",  1, 8'h02, 1, 1, 8'h02, 0, 1, 0);
        add("ars_dec",   0, 8'h00, 1, 0, 8'h01, 0, 1, 0);
        add("ars_tc",    0, 8'h00, 1, 1, 8'h02, 1, 1, 0);
        // Load from DONE clears done
        add("d_load",    1, 8'h01, 1, 0, 8'h01, 0, 1, 0);
        add("d_tc",      0, 8'h00, 1, 0, 8'h00, 1, 0, 1);
        add("d_reload",  1, 8'h07, 0, 0, 8'h07, 0, 1, 0);

        foreach (vq[i]) begin
            drive(vq[i].load, vq[i].lv, vq[i].en, vq[i].ar);
            step();
            chk(vq[i].name, vq[i].c, vq[i].tc, vq[i].busy, vq[i].done);
        end
`else
        // Prescale 4: one decrement per four enabled cycles
        drive(1'b1, 8'h02, 1'b1, 1'b0);
        step();
        chk("ps_load", 8'h02, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k < 4)       chk("ps_hold02", 8'h02, 1'b0, 1'b1, 1'b0);
            else if (k < 8)  chk("ps_hold01", 8'h01, 1'b0, 1'b1, 1'b0);
            else             chk("ps_tc",     8'h00, 1'b1, 1'b0, 1'b1);
        end
        drive(1'b1, 8'h03, 1'b1, 1'b0);
        step();
        chk("ps_rl_load", 8'h03, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("ps_rl_mid", 8'h03, 1'b0, 1'b1, 1'b0);
        end
        drive(1'b1, 8'h03, 1'b1, 1'b0);
        step();
        chk("ps_rl_again", 8'h03, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k < 4) chk("ps_phase_hold", 8'h03, 1'b0, 1'b1, 1'b0);
            else       chk("ps_phase_dec",  8'h02, 1'b0, 1'b1, 1'b0);
        end
`endif

        // Asynchronous reset in the middle of a count
        drive(1'b1, 8'h05, 1'b1, 1'b1);
        step();
        chk("mid_load", 8'h05, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tff_down_timer.md
Name: tff_down_timer

Overview:
- Loadable synchronous down-counter/timer built from a generate-chain of T flip-flops.
- It is the count-down counterpart to the team's T-FF synchronous up-counter.
- A preset value is loaded, decremented on enabled cycles, and a terminal-count pulse is raised at zero.
- Supports one-shot and auto-reload modes; used as the timeout/tick source on the lab board (switch inputs, LED outputs).

Parameters:
- WIDTH, 8, counter width in bits (2..16).
- PRESCALE, 4, enable-cycles per decrement when TFF_DOWN_PRESCALE_EN is defined (>=2); ignored otherwise.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable; counter holds when low.
- load  in  1  synchronous load strobe; highest priority after reset.
- load_val  in  WIDTH  preset value captured on load.
- auto_reload  in  1  1 = reload from latched preset at terminal count; 0 = one-shot.
- count  out  WIDTH  current counter value.
- tc  out  1  terminal-count pulse, one cycle.
- busy  out  1  high while in RUN.
- done  out  1  high in DONE (one-shot expired), held until next load.

Behaviour:
- Reset (rst_n=0, asynchronous): count=0, tc=0, busy=0, done=0, reload register=0, state=IDLE.
- Counter core: WIDTH T flip-flops. T_i = tick & (count[i-1:0]==0), with T_0 = tick. Toggling happens only in RUN.
- tick = en. The prescaled variant is described under Optional Feature.
- States:
  - IDLE: count holds; en ignored.
  - RUN: busy=1.
  - DONE: count=0, done=1; en ignored.
- Load, taken from any state:
  - Next edge: count<=load_val, reload register<=load_val, tc<=0, done<=0.
  - load_val!=0: go to RUN.
  - load_val==0: go to IDLE; no tc pulse.
- RUN, tick=1, count>1: count decrements by 1 on the next edge.
- RUN, tick=1, count==1:
  - tc=1 for exactly the following cycle.
  - auto_reload=1: count<=reload register; stay in RUN.
  - auto_reload=0: count<=0; go to DONE. busy falls and done rises in the same cycle that tc=1.
- RUN, tick=0: count holds, tc=0.
- No underflow: count never wraps from 0 to all-ones. The chain is gated out of RUN.
- Load coinciding with a count==1 decrement: load wins. The new value is loaded and tc is not pulsed.
- auto_reload is sampled at the count==1 decrement only. Changing it mid-count has no other effect.
- Latency: load to count valid = 1 cycle. The last enabled decrement to tc = 1 cycle (registered output).
- Reset mid-count: immediate return to reset values. No tc is emitted.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: TFF_DOWN_PRESCALE_EN.
- Defined:
  - An internal counter of $clog2(PRESCALE) bits advances on en in RUN.
  - tick=1 on the en cycle where the prescaler equals PRESCALE-1, and the prescaler wraps to 0.
  - The prescaler clears on load, on reset, and on leaving RUN.
  - The count therefore decrements once per PRESCALE enabled cycles.
  - tc timing relative to the decrementing tick is unchanged.
- Undefined: tick=en, no prescaler logic is instantiated, and PRESCALE is unused.

Test Plan:
- Reset: hold rst_n=0 with en=1, load=1 -> count=0, tc=0, busy=0, done=0 throughout. Release -> state remains IDLE, count=0.
- One-shot: load_val=8'h05, auto_reload=0, en=1 continuously -> count sequence 05,04,03,02,01,00. tc high exactly 1 cycle with count=00. done=1 and busy=0 from then on. Count stays 00 for 10 further cycles.
- Auto-reload: load_val=8'h03, auto_reload=1, en=1 for 12 cycles -> count 03,02,01,03,02,01,... tc pulses every 3 cycles (4 pulses). done never asserts.
- Enable gating plus T-chain carry: load_val=8'h10, toggle en every other cycle -> count steps 10,0F,0E only on en=1 cycles. The 10->0F transition flips 5 bits in one edge.
- Collision: count=01 in RUN, assert load=1 with load_val=8'hA0 and en=1 on the same cycle -> next count=A0, tc stays 0, busy=1.
- Prescale (TFF_DOWN_PRESCALE_EN, PRESCALE=4): load_val=8'h02, en=1 -> count changes every 4 cycles (02 to 01 to 00). tc arrives 8 cycles after load. A reload mid-period restarts the 4-cycle phase.
